// File: rtl/b2oh_pkg.sv
// Shared definitions for the b2oh stimulus/decoder slice.
//   state_t     : sweep generator FSM encoding (IDLE/SWEEP/DONE)
//   clog2_min1  : ceil(log2(v)) clamped to at least 1, used to size counters
package b2oh_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SWEEP = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic int clog2_min1(input int v);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/b2oh_step_tick.sv
// STEP_DIV prescaler: asserts tick on the enabled cycle that completes
// STEP_DIV enabled cycles, then restarts from zero.
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-high
//   clr  : synchronous clear of the count
//   en   : count enable; 0 freezes the count
//   tick : combinational, en && count == STEP_DIV-1
module b2oh_step_tick
  import b2oh_pkg::*;
#(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = clog2_min1(STEP_DIV);
  localparam logic [PW-1:0] LAST = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] cnt;

  // With STEP_DIV=1 LAST is 0, so every enabled cycle is a tick.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/b2oh_sweep_gen.sv
// Sweep generator feeding the binary input of a b2oh decoder. Walks every
// N-bit code once (up or down, chosen at start), holding each code for
// STEP_DIV enabled cycles, then pulses done. A load path presets the code.
// Optional feature macro: SWEEP_AUTO_RESTART_EN -- start asserted in the
// DONE cycle chains straight into a new sweep from the current code.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   en              : step enable; 0 freezes prescaler and code
//   start, up       : begin sweep (IDLE only), direction latched at start
//   load, load_val  : preset code (IDLE only)
//   abort           : synchronous sweep cancel
//   binary          : current code
//   valid, busy     : binary is a sweep code / sweep in progress
//   done, wrap      : one-cycle pulses at sweep end / modular wrap of binary
module b2oh_sweep_gen
  import b2oh_pkg::*;
#(
  parameter int N        = 3,
  parameter int STEP_DIV = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         start,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         abort,
  output logic [N-1:0] binary,
  output logic         valid,
  output logic         busy,
  output logic         done,
  output logic         wrap
);

  localparam logic [N-1:0] ONE      = N'(1);
  localparam logic [N-1:0] MAX_CODE = {N{1'b1}};

  state_t       state;
  logic         dir;
  logic [N-1:0] remaining;
  logic         tick;
  logic         tick_clr;
  logic [N-1:0] step_code;
  logic         step_wraps;

  // Prescaler only runs inside a sweep; abort also clears it so a
  // following sweep always starts with a full hold on its first code.
  assign tick_clr = (state != SWEEP) || abort;

  assign step_code  = dir ? (binary + ONE) : (binary - ONE);
  assign step_wraps = dir ? (step_code == '0) : (step_code == MAX_CODE);

  b2oh_step_tick #(
    .STEP_DIV(STEP_DIV)
  ) u_step_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .en  (en),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= 1'b1;
      remaining <= '0;
      binary    <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          // load and start together: the loaded value is the first code.
          if (load) binary <= load_val;
          if (start) begin
            state     <= SWEEP;
            dir       <= up;
            remaining <= MAX_CODE;
            valid     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SWEEP: begin
          if (abort) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (tick) begin
            // remaining counts steps still to take; the 2^N-th tick ends
            // the sweep without moving binary.
            if (remaining != '0) begin
              binary    <= step_code;
              remaining <= remaining - ONE;
              wrap      <= step_wraps;
            end else begin
              state <= DONE;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef SWEEP_AUTO_RESTART_EN
          if (start) begin
            state     <= SWEEP;
            dir       <= up;
            remaining <= MAX_CODE;
            valid     <= 1'b1;
            busy      <= 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_b2oh_sweep_gen.sv
// Bench for b2oh_sweep_gen: two instances (STEP_DIV=1 and STEP_DIV=2) share
// stimulus; a sequence-level model predicts every output each cycle, and
// directed sections pin expected code orders, lengths and pulses.
module tb_b2oh_sweep_gen;

  localparam int N = 3;
  localparam int M = 1 << N;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, start, up, load, abort;
  logic [N-1:0] load_val;

  logic [N-1:0] dbin [2];
  logic         dval [2];
  logic         dbsy [2];
  logic         ddn  [2];
  logic         dwr  [2];

  int total = 0;
  int bad   = 0;

  b2oh_sweep_gen #(.N(N), .STEP_DIV(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .start(start), .up(up), .load(load),
    .load_val(load_val), .abort(abort), .binary(dbin[0]), .valid(dval[0]),
    .busy(dbsy[0]), .done(ddn[0]), .wrap(dwr[0])
  );

  b2oh_sweep_gen #(.N(N), .STEP_DIV(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .start(start), .up(up), .load(load),
    .load_val(load_val), .abort(abort), .binary(dbin[1]), .valid(dval[1]),
    .busy(dbsy[1]), .done(ddn[1]), .wrap(dwr[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sdiv(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  // Model: ph 0=idle 1=sweeping 2=done cycle. While sweeping, the code is
  // start + k*dir where k = enabled cycles consumed / STEP_DIV.
  int ph  [2];
  int cur [2];
  int st  [2];
  int dr  [2];
  int ec  [2];
  int edn [2];
  int ewr [2];
  int mk;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      edn[i] = 0;
      ewr[i] = 0;
      if (rst) begin
        ph[i] = 0; cur[i] = 0; st[i] = 0; dr[i] = 1; ec[i] = 0;
      end else begin
        case (ph[i])
          0: begin
            if (load) cur[i] = int'(load_val);
            if (start) begin
              ph[i] = 1; st[i] = cur[i]; dr[i] = int'(up); ec[i] = 0;
            end
          end
          1: begin
            if (abort) ph[i] = 0;
            else if (en) begin
              ec[i]++;
              if (ec[i] % sdiv(i) == 0) begin
                mk = ec[i] / sdiv(i);
                if (mk == M) begin
                  ph[i] = 2; edn[i] = 1;
                end else begin
                  cur[i] = (st[i] + (dr[i] != 0 ? mk : -mk)) & (M - 1);
                  if ((dr[i] != 0 && cur[i] == 0) || (dr[i] == 0 && cur[i] == M - 1))
                    ewr[i] = 1;
                end
              end
            end
          end
          default: begin
            ph[i] = 0;
`ifdef SWEEP_AUTO_RESTART_EN
            if (start) begin
              ph[i] = 1; st[i] = cur[i]; dr[i] = int'(up); ec[i] = 0;
            end
`endif
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d binary", i), int'(dbin[i]), cur[i]);
        chk($sformatf("u%0d valid", i), int'(dval[i]), int'(ph[i] == 1));
        chk($sformatf("u%0d busy", i), int'(dbsy[i]), int'(ph[i] == 1));
        chk($sformatf("u%0d done", i), int'(ddn[i]), edn[i]);
        chk($sformatf("u%0d wrap", i), int'(dwr[i]), ewr[i]);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((dbsy[0] || dbsy[1] || ddn[0] || ddn[1]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle timeout", int'(n < 200), 1);
  endtask

  int e2 [8] = '{6, 7, 0, 1, 2, 3, 4, 5};
  int o3 [8] = '{3, 2, 1, 0, 7, 6, 5, 4};
  int k, ecnt, gap;

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; up = 1'b1; load = 1'b0;
    load_val = '0; abort = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset binary", int'(dbin[0]), 0);
    chk("reset valid", int'(dval[0]), 0);
    chk("reset busy", int'(dbsy[1]), 0);
    chk("reset done", int'(ddn[1]), 0);

    // Full up sweep from 0, STEP_DIV=1.
    en = 1'b1; up = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("t1 code", int'(dbin[0]), c);
      chk("t1 valid", int'(dval[0]), 1);
      @(negedge clk);
    end
    chk("t1 done", int'(ddn[0]), 1);
    chk("t1 valid end", int'(dval[0]), 0);
    chk("t1 last code", int'(dbin[0]), 7);
    chk("t1 wrap", int'(dwr[0]), 0);
    wait_idle();

    // Load 6 and start together: wrap after 7->0.
    load = 1'b1; load_val = 3'd6; start = 1'b1; up = 1'b1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("t2 code", int'(dbin[0]), e2[c]);
      chk("t2 wrap", int'(dwr[0]), int'(c == 2));
      @(negedge clk);
    end
    chk("t2 done", int'(ddn[0]), 1);
    chk("t2 last code", int'(dbin[0]), 5);
    wait_idle();

    // STEP_DIV=2 down sweep from 3 with three en=0 cycles.
    load = 1'b1; load_val = 3'd3; start = 1'b1; up = 1'b0;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    k = 0; ecnt = 0;
    while (!ddn[1] && k < 60) begin
      if (dval[1]) chk("t3 order", int'(dbin[1]), o3[ecnt / 2]);
      en = !(k >= 4 && k < 7);
      @(negedge clk);
      if (en) ecnt++;
      k++;
    end
    chk("t3 length", k, 19);
    chk("t3 last code", int'(dbin[1]), 4);
    en = 1'b1;
    wait_idle();

    // Abort on the 4th code of an up sweep from 0.
    load = 1'b1; load_val = 3'd0; start = 1'b1; up = 1'b1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4 4th code", int'(dbin[0]), 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4 valid", int'(dval[0]), 0);
    chk("t4 busy", int'(dbsy[0]), 0);
    chk("t4 done", int'(ddn[0]), 0);
    chk("t4 binary", int'(dbin[0]), 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("t4 resweep", int'(dbin[0]), (3 + c) % 8);
      @(negedge clk);
    end
    wait_idle();

    // Asynchronous reset between edges mid-sweep.
    load = 1'b1; load_val = 3'd5; start = 1'b1; up = 1'b0;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5 binary", int'(dbin[0]), 0);
    chk("t5 valid", int'(dval[1]), 0);
    chk("t5 busy", int'(dbsy[0]), 0);
    chk("t5 done", int'(ddn[1]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5 quiet", int'(dval[0]), 0);

    // start held high through the done cycle.
    load = 1'b1; load_val = 3'd0; start = 1'b1; up = 1'b1;
    @(negedge clk);
    load = 1'b0;
    k = 0;
    while (!ddn[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t6 first sweep", k, 8);
    gap = 0;
    while (!dval[0] && gap < 10) begin
      @(negedge clk);
      gap++;
    end
`ifdef SWEEP_AUTO_RESTART_EN
    chk("t6 restart gap", gap, 1);
`else
    chk("t6 restart gap", gap, 2);
`endif
    start = 1'b0;
    wait_idle();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      en       = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 5) == 0);
      load     = ($urandom_range(0, 4) == 0);
      load_val = N'($urandom_range(0, M - 1));
      up       = 1'($urandom_range(0, 1));
      abort    = ($urandom_range(0, 40) == 0);
      @(negedge clk);
    end
    en = 1'b1; start = 1'b0; load = 1'b0; abort = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
